regfile_writeback: RTL and testbench

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

---
 rtl/regfile_writeback.sv | 111 +++++++++++
 tb/tb_regfile_writeback.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// Register-file write port arbiter: single-cycle ALU results take priority over a
// small FIFO of returning loads, with WAW squash of stale buffered loads.
module regfile_writeback #(
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       alu_valid,
    input  logic [5:0]                 alu_rd,
    input  logic [31:0]                alu_data,
    input  logic                       ld_valid,
    input  logic [5:0]                 ld_rd,
    input  logic [31:0]                ld_data,
    output logic                       ld_ready,
    output logic [5:0]                 RD,
    output logic [31:0]                WriteData,
    output logic                       RegWrite,
    input  logic [5:0]                 query_rd,
    output logic                       query_pending,
    output logic [$clog2(DEPTH):0]     ld_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0] ent_valid;
    logic [4:0]       ent_rd   [DEPTH];
    logic [31:0]      ent_data [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;

    logic [4:0] alu_r;
    logic [4:0] ld_r;
    logic [4:0] q_r;
    logic       alu_write;
    logic       pop;
    logic       accept;
    logic       push;
    logic       unused_bits;

    assign alu_r       = alu_rd[4:0];
    assign ld_r        = ld_rd[4:0];
    assign q_r         = query_rd[4:0];
    assign unused_bits = ^{alu_rd[5], ld_rd[5], query_rd[5]};

    assign ld_ready  = !reset && (count < CW'(DEPTH));
    assign ld_count  = count;
    assign alu_write = !reset && alu_valid && (alu_r != 5'd0);
    assign pop       = !reset && !alu_write && (count != '0);
    assign accept    = ld_valid && ld_ready;
    // A load racing an ALU write to the same register is older, so it is dropped.
    assign push      = accept && (ld_r != 5'd0) && !(alu_write && (ld_r == alu_r));

    always_comb begin
        query_pending = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((q_r != 5'd0) && ent_valid[i] && (ent_rd[i] == q_r)) begin
                query_pending = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ent_valid <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
        end else begin
            // Squashed entries stay in the FIFO and retire silently when they reach the head.
            for (int i = 0; i < DEPTH; i++) begin
                if (alu_write && (ent_rd[i] == alu_r)) begin
                    ent_valid[i] <= 1'b0;
                end
            end
            if (pop) begin
                ent_valid[head] <= 1'b0;
                head            <= head + PW'(1);
            end
            if (push) begin
                ent_valid[tail] <= 1'b1;
                ent_rd[tail]    <= ld_r;
                ent_data[tail]  <= ld_data;
                tail            <= tail + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            RegWrite  <= 1'b0;
            RD        <= '0;
            WriteData <= '0;
        end else if (alu_write) begin
            RegWrite  <= 1'b1;
            RD        <= {1'b0, alu_r};
            WriteData <= alu_data;
        end else if (pop && ent_valid[head]) begin
            RegWrite  <= 1'b1;
            RD        <= {1'b0, ent_rd[head]};
            WriteData <= ent_data[head];
        end else begin
            RegWrite  <= 1'b0;
            RD        <= '0;
            WriteData <= '0;
        end
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback: a queue-based model predicts each cycle's
// register-file write and a monitor compares the registered outputs one cycle later.
module tb_regfile_writeback;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    logic          clock;
    logic          reset;
    logic          alu_valid;
    logic [5:0]    alu_rd;
    logic [31:0]   alu_data;
    logic          ld_valid;
    logic [5:0]    ld_rd;
    logic [31:0]   ld_data;
    logic          ld_ready;
    logic [5:0]    RD;
    logic [31:0]   WriteData;
    logic          RegWrite;
    logic [5:0]    query_rd;
    logic          query_pending;
    logic [CW-1:0] ld_count;

    wr_t    sb[$];
    entry_t model_q[$];
    int     checks;
    int     errors;

    regfile_writeback #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
        .RD(RD), .WriteData(WriteData), .RegWrite(RegWrite),
        .query_rd(query_rd), .query_pending(query_pending), .ld_count(ld_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic modelPending(input logic [4:0] q);
        logic hit;
        hit = 1'b0;
        if (q != 5'd0) begin
            foreach (model_q[i]) if (model_q[i].valid && model_q[i].rd == q) hit = 1'b1;
        end
        return hit;
    endfunction

    // Next-cycle write: ALU wins, otherwise the oldest buffered load retires.
    task automatic modelStep(input logic rst, input logic av, input logic [4:0] ar, input logic [31:0] ad,
                             input logic lv, input logic [4:0] lr, input logic [31:0] ldd);
        wr_t    w;
        entry_t e;
        logic   alu_w;
        logic   acc;
        w     = '{we: 1'b0, rd: 5'd0, data: 32'd0};
        alu_w = !rst && av && (ar != 5'd0);
        acc   = lv && !rst && (model_q.size() < DEPTH);
        if (alu_w) begin
            w = '{we: 1'b1, rd: ar, data: ad};
        end else if (!rst && model_q.size() > 0) begin
            e = model_q.pop_front();
            if (e.valid) w = '{we: 1'b1, rd: e.rd, data: e.data};
        end
        if (alu_w) begin
            foreach (model_q[i]) if (model_q[i].rd == ar) model_q[i].valid = 1'b0;
        end
        if (acc && (lr != 5'd0) && !(alu_w && lr == ar))
            model_q.push_back('{valid: 1'b1, rd: lr, data: ldd});
        if (rst) model_q.delete();
        sb.push_back(w);
    endtask

    task automatic applyStimulus(input logic rst, input logic av, input logic [5:0] ar, input logic [31:0] ad,
                                 input logic lv, input logic [5:0] lr, input logic [31:0] ldd,
                                 input logic [5:0] qr);
        @(negedge clock);
        reset     = rst;
        alu_valid = av;
        alu_rd    = ar;
        alu_data  = ad;
        ld_valid  = lv;
        ld_rd     = lr;
        ld_data   = ldd;
        query_rd  = qr;
        #1;
        checkOutput("ld_ready", {31'd0, ld_ready}, {31'd0, !rst && (model_q.size() < DEPTH)});
        checkOutput("ld_count", {{(32-CW){1'b0}}, ld_count}, model_q.size());
        checkOutput("query_pending", {31'd0, query_pending}, {31'd0, modelPending(qr[4:0])});
        modelStep(rst, av, ar[4:0], ad, lv, lr[4:0], ldd);
    endtask

    task automatic idle(input int n, input logic [5:0] qr);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0, qr);
    endtask

    // Monitor: every cycle's registered write port is compared against the scoreboard.
    initial begin
        wr_t w;
        forever begin
            @(posedge clock);
            #2;
            if (sb.size() > 0) begin
                w = sb.pop_front();
                checkOutput("reg_write", {31'd0, RegWrite}, {31'd0, w.we});
                checkOutput("rd", {26'd0, RD}, {27'd0, w.rd});
                checkOutput("write_data", WriteData, w.data);
            end
        end
    end

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        alu_valid = 1'b0;
        alu_rd    = '0;
        alu_data  = '0;
        ld_valid  = 1'b0;
        ld_rd     = '0;
        ld_data   = '0;
        query_rd  = '0;

        applyStimulus(1'b1, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0, 6'd0);
        applyStimulus(1'b1, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0, 6'd0);

        // Single ALU write into an idle buffer.
        applyStimulus(1'b0, 1'b1, 6'd5, 32'h1234, 1'b0, 6'd0, 32'd0, 6'd0);
        idle(1, 6'd0);

        // Three loads drain in order.
        applyStimulus(1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 6'd3, 32'h3333, 6'd3);
        applyStimulus(1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 6'd4, 32'h4444, 6'd4);
        applyStimulus(1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 6'd6, 32'h6666, 6'd6);
        idle(4, 6'd0);

        // Fill the buffer while the ALU hogs the port; fifth load must be refused.
        for (int k = 0; k < 5; k++)
            applyStimulus(1'b0, 1'b1, 6'd7, 32'h7000 + k, 1'b1, 6'(10 + k), 32'hA0 + k, 6'(10 + k));
        checkOutput("full_count", {{(32-CW){1'b0}}, ld_count}, DEPTH);
        idle(6, 6'd12);

        // WAW squash of a buffered load.
        applyStimulus(1'b0, 1'b1, 6'd7, 32'h77, 1'b1, 6'd9, 32'hAAAA, 6'd9);
        applyStimulus(1'b0, 1'b1, 6'd9, 32'hBBBB, 1'b0, 6'd0, 32'd0, 6'd9);
        idle(3, 6'd9);

        // Same-cycle collision, and writes to register 0 (bit 5 set) never appear.
        applyStimulus(1'b0, 1'b1, 6'd2, 32'h2222, 1'b1, 6'd2, 32'hDEAD, 6'd2);
        applyStimulus(1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 6'h20, 32'hBAD0, 6'h20);
        applyStimulus(1'b0, 1'b1, 6'h20, 32'hBAD1, 1'b0, 6'd0, 32'd0, 6'd0);
        applyStimulus(1'b0, 1'b1, 6'h21, 32'h2101, 1'b1, 6'h23, 32'h2303, 6'd3);
        idle(3, 6'd0);

        // Reset with three entries buffered.
        for (int k = 0; k < 3; k++)
            applyStimulus(1'b0, 1'b1, 6'd8, 32'h800 + k, 1'b1, 6'(20 + k), 32'hC0 + k, 6'd21);
        applyStimulus(1'b1, 1'b0, 6'd0, 32'd0, 1'b1, 6'd25, 32'hFF, 6'd21);
        idle(4, 6'd21);

        // Randomized traffic with small register ranges to provoke squashes and collisions.
        for (int c = 0; c < 400; c++) begin
            applyStimulus(($urandom_range(0, 79) == 0),
                          ($urandom_range(0, 9) < 5),
                          {1'($urandom_range(0, 1)), 5'($urandom_range(0, 7))},
                          $urandom,
                          ($urandom_range(0, 9) < 7),
                          {1'($urandom_range(0, 1)), 5'($urandom_range(0, 7))},
                          $urandom,
                          {1'b0, 5'($urandom_range(0, 7))});
        end
        idle(DEPTH + 2, 6'd0);

        @(posedge clock);
        #3;
        checkOutput("scoreboard_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
